// File: rtl/cpu_pkg.sv
// Shared constants for the SAP-style control sequencer: opcodes, control-word
// bit positions, the idle control word and the sequencer state encoding.
package cpu_pkg;

  localparam int CTRL_W   = 15;
  localparam int OPCODE_W = 4;

  // Opcodes (IR[7:4]); 9..D are unassigned and behave as NOP
  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  // Control word bit positions: {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}
  localparam int B_CP   = 14;
  localparam int B_EP   = 13;
  localparam int B_LP   = 12;
  localparam int B_NLMA = 11;
  localparam int B_NLMD = 10;
  localparam int B_NCE  = 9;
  localparam int B_NLR  = 8;
  localparam int B_NLI  = 7;
  localparam int B_NEI  = 6;
  localparam int B_NLA  = 5;
  localparam int B_EA   = 4;
  localparam int B_SUB  = 3;
  localparam int B_EU   = 2;
  localparam int B_NLB  = 1;
  localparam int B_NLO  = 0;

  // Every active-low strobe deasserted, every active-high strobe low
  localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'h0FE3;

  // Sequencer states; T-states encode their own index so t_state is a slice.
  // Encodings 6,7 and 10..15 are illegal and fall back to PAUSE.
  localparam logic [3:0] ST_T0    = 4'd0;
  localparam logic [3:0] ST_T1    = 4'd1;
  localparam logic [3:0] ST_T2    = 4'd2;
  localparam logic [3:0] ST_T3    = 4'd3;
  localparam logic [3:0] ST_T4    = 4'd4;
  localparam logic [3:0] ST_T5    = 4'd5;
  localparam logic [3:0] ST_PAUSE = 4'd8;
  localparam logic [3:0] ST_HALT  = 4'd9;

  // Final T-state of each instruction (the step after which we return to T0/PAUSE)
  function automatic logic [2:0] last_t(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LDA:                 last_t = 3'd4;
      OP_ADD, OP_SUB, OP_STA: last_t = 3'd5;
      default:                last_t = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ucode_rom.sv
// Combinational microcode ROM: {t_state, opcode, cf, zf} -> control word.
// Holds no state; the caller gates the output to idle outside T0..T5.
module cpu_ucode_rom
  import cpu_pkg::*;
(
  input  logic [2:0]          t_state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                cf,
  input  logic                zf,
  output logic [CTRL_W-1:0]   ctrl
);

  // Start from idle and flip only the strobes each step needs
  always_comb begin
    ctrl = CTRL_IDLE;
    case (t_state)
      3'd0: begin                      // PC -> MAR
        ctrl[B_EP]   = 1'b1;
        ctrl[B_NLMA] = 1'b0;
      end
      3'd1: ctrl[B_CP] = 1'b1;         // PC++
      3'd2: begin                      // RAM -> IR
        ctrl[B_NCE] = 1'b0;
        ctrl[B_NLI] = 1'b0;
      end
      3'd3: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin  // operand address -> MAR
            ctrl[B_NEI]  = 1'b0;
            ctrl[B_NLMA] = 1'b0;
          end
          OP_LDI: begin
            ctrl[B_NEI] = 1'b0;
            ctrl[B_NLA] = 1'b0;
          end
          OP_JMP: begin
            ctrl[B_NEI] = 1'b0;
            ctrl[B_LP]  = 1'b1;
          end
          OP_JC: if (cf) begin
            ctrl[B_NEI] = 1'b0;
            ctrl[B_LP]  = 1'b1;
          end
          OP_JZ: if (zf) begin
            ctrl[B_NEI] = 1'b0;
            ctrl[B_LP]  = 1'b1;
          end
          OP_OUT: begin
            ctrl[B_EA]  = 1'b1;
            ctrl[B_NLO] = 1'b0;
          end
          default: ;                   // NOP, HLT, unassigned
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_LDA: begin
            ctrl[B_NCE] = 1'b0;
            ctrl[B_NLA] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            ctrl[B_NCE] = 1'b0;
            ctrl[B_NLB] = 1'b0;
          end
          OP_STA: begin                // A -> MDR
            ctrl[B_EA]   = 1'b1;
            ctrl[B_NLMD] = 1'b0;
          end
          default: ;
        endcase
      end
      3'd5: begin
        case (opcode)
          OP_ADD: begin
            ctrl[B_EU]  = 1'b1;
            ctrl[B_NLA] = 1'b0;
          end
          OP_SUB: begin
            ctrl[B_EU]  = 1'b1;
            ctrl[B_SUB] = 1'b1;
            ctrl[B_NLA] = 1'b0;
          end
          OP_STA: ctrl[B_NLR] = 1'b0;  // MDR -> RAM
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// T-state sequencer for the SAP-style CPU: owns the state register, run/HALT
// handling and idle gating of the control word; decoding lives in cpu_ucode_rom.
module cpu_control_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                cf,
  input  logic                zf,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [2:0]          t_state,
  output logic                halted
);

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic              in_t;
  logic [CTRL_W-1:0] rom_ctrl;

  assign in_t    = (state <= ST_T5);
  assign t_state = in_t ? state[2:0] : 3'd0;
  assign halted  = (state == ST_HALT);

  cpu_ucode_rom u_rom (
    .t_state (t_state),
    .opcode  (opcode),
    .cf      (cf),
    .zf      (zf),
    .ctrl    (rom_ctrl)
  );

  // Reset gating is combinational so an aborted instruction drops its strobes at once
  always_comb begin
    ctrl = CTRL_IDLE;
    if (rst_n && in_t) ctrl = rom_ctrl;
  end

  // Next state: fetch is fixed, execute length comes from the opcode; run is
  // looked at only on an instruction boundary or while paused
  always_comb begin
    state_nxt = ST_PAUSE;
    case (state)
      ST_PAUSE: state_nxt = run ? ST_T0 : ST_PAUSE;
      ST_T0:    state_nxt = ST_T1;
      ST_T1:    state_nxt = ST_T2;
      ST_T2:    state_nxt = ST_T3;
      ST_T3, ST_T4, ST_T5: begin
        if (state == ST_T3 && opcode == OP_HLT)
          state_nxt = ST_HALT;
        else if (state[2:0] >= last_t(opcode))
          state_nxt = run ? ST_T0 : ST_PAUSE;
        else
          state_nxt = state + 4'd1;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_PAUSE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_PAUSE;
    else        state <= state_nxt;
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: table of per-instruction control words run
// back to back, plus hand sequences for reset abort, pause and halt.
module tb_cpu_control_sequencer;

  localparam logic [14:0] IDLE  = 15'h0FE3;
  localparam logic [14:0] F0    = 15'h27E3;
  localparam logic [14:0] F1    = 15'h4FE3;
  localparam logic [14:0] F2    = 15'h0D63;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [3:0]  opcode;
  logic        cf, zf;
  logic [14:0] ctrl;
  logic [2:0]  t_state;
  logic        halted;

  int errors = 0;
  int checks = 0;

  cpu_control_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .opcode  (opcode),
    .cf      (cf),
    .zf      (zf),
    .ctrl    (ctrl),
    .t_state (t_state),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [14:0] c;
    logic        h;
    string       name;
  } exp_s;

  exp_s sb[$];

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        cf;
    logic        zf;
    int          len;
    logic [14:0] c3, c4, c5;
  } vec_s;

  vec_s vecs[$];

  task automatic compare(input exp_s e);
    checks++;
    if (t_state !== e.t || ctrl !== e.c || halted !== e.h) begin
      errors++;
      $display("FAIL %s: got t_state=%0d ctrl=%h halted=%b, want t_state=%0d ctrl=%h halted=%b",
               e.name, t_state, ctrl, halted, e.t, e.c, e.h);
    end
  endtask

  // Push expectation, compare on the falling edge, return just after the next rising edge
  task automatic expect_cycle(input logic [2:0] t, input logic [14:0] c,
                              input logic h, input string nm);
    exp_s e;
    e.t = t; e.c = c; e.h = h; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb.pop_front();
      compare(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_now(input logic [2:0] t, input logic [14:0] c,
                           input logic h, input string nm);
    exp_s e;
    e.t = t; e.c = c; e.h = h; e.name = nm;
    compare(e);
  endtask

  // At most one bus driver may be enabled at any time
  always @(negedge clk) begin
    int drv;
    if (rst_n === 1'b1) begin
      drv = int'(ctrl[13]) + int'(!ctrl[6]) + int'(!ctrl[9]) + int'(ctrl[4]) + int'(ctrl[2]);
      checks++;
      if (drv > 1) begin
        errors++;
        $display("FAIL bus_drivers: got %0d drivers ctrl=%h, want at most 1", drv, ctrl);
      end
    end
  end

  function automatic vec_s mk(input string n, input logic [3:0] op, input logic c, input logic z,
                              input int len, input logic [14:0] c3, input logic [14:0] c4,
                              input logic [14:0] c5);
    vec_s v;
    v.name = n; v.op = op; v.cf = c; v.zf = z; v.len = len;
    v.c3 = c3; v.c4 = c4; v.c5 = c5;
    return v;
  endfunction

  initial begin
    logic [14:0] ec;
    vecs.push_back(mk("nop",      4'h0, 0, 0, 4, IDLE,     IDLE,     IDLE));
    vecs.push_back(mk("lda",      4'h1, 0, 0, 5, 15'h07A3, 15'h0DC3, IDLE));
    vecs.push_back(mk("add",      4'h2, 0, 0, 6, 15'h07A3, 15'h0DE1, 15'h0FC7));
    vecs.push_back(mk("sub",      4'h3, 0, 0, 6, 15'h07A3, 15'h0DE1, 15'h0FCF));
    vecs.push_back(mk("sta",      4'h4, 0, 0, 6, 15'h07A3, 15'h0BF3, 15'h0EE3));
    vecs.push_back(mk("ldi",      4'h5, 0, 0, 4, 15'h0F83, IDLE,     IDLE));
    vecs.push_back(mk("jmp",      4'h6, 0, 0, 4, 15'h1FA3, IDLE,     IDLE));
    vecs.push_back(mk("jc_cf0",   4'h7, 0, 1, 4, IDLE,     IDLE,     IDLE));
    vecs.push_back(mk("jc_cf1",   4'h7, 1, 0, 4, 15'h1FA3, IDLE,     IDLE));
    vecs.push_back(mk("jz_zf0",   4'h8, 1, 0, 4, IDLE,     IDLE,     IDLE));
    vecs.push_back(mk("jz_zf1",   4'h8, 0, 1, 4, 15'h1FA3, IDLE,     IDLE));
    vecs.push_back(mk("out",      4'hE, 0, 0, 4, 15'h0FF2, IDLE,     IDLE));
    vecs.push_back(mk("undef_9",  4'h9, 1, 1, 4, IDLE,     IDLE,     IDLE));
    vecs.push_back(mk("undef_d",  4'hD, 1, 1, 4, IDLE,     IDLE,     IDLE));

    rst_n = 1'b0; run = 1'b0; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
    #1 check_now(0, IDLE, 0, "reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_cycle(0, IDLE, 0, "pause_run0");
    run = 1'b1;
    expect_cycle(0, IDLE, 0, "pause_before_start");

    // Table: instructions back to back with run held high; flags random outside T3
    foreach (vecs[i]) begin
      for (int t = 0; t < vecs[i].len; t++) begin
        opcode = vecs[i].op;
        cf = (t == 3) ? vecs[i].cf : 1'($urandom);
        zf = (t == 3) ? vecs[i].zf : 1'($urandom);
        case (t)
          0: ec = F0;
          1: ec = F1;
          2: ec = F2;
          3: ec = vecs[i].c3;
          4: ec = vecs[i].c4;
          default: ec = vecs[i].c5;
        endcase
        expect_cycle(3'(t), ec, 0, vecs[i].name);
      end
    end

    // Reset during T4 of ADD aborts it immediately
    opcode = 4'h2; cf = 1'b0; zf = 1'b0;
    expect_cycle(0, F0, 0, "add_abort_t0");
    expect_cycle(1, F1, 0, "add_abort_t1");
    expect_cycle(2, F2, 0, "add_abort_t2");
    expect_cycle(3, 15'h07A3, 0, "add_abort_t3");
    check_now(4, 15'h0DE1, 0, "add_abort_t4");
    #2 rst_n = 1'b0;
    #1 check_now(0, IDLE, 0, "rst_mid_add");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    expect_cycle(0, F0, 0, "rst_release_t0");

    // STA with run dropped in T4: store completes, then pause
    opcode = 4'h4;
    expect_cycle(1, F1, 0, "sta_t1");
    expect_cycle(2, F2, 0, "sta_t2");
    expect_cycle(3, 15'h07A3, 0, "sta_t3");
    run = 1'b0;
    expect_cycle(4, 15'h0BF3, 0, "sta_t4_run_low");
    expect_cycle(5, 15'h0EE3, 0, "sta_t5_still_writes");
    repeat (3) expect_cycle(0, IDLE, 0, "paused_idle");
    run = 1'b1;
    expect_cycle(0, IDLE, 0, "paused_last");
    expect_cycle(0, F0, 0, "resume_t0");

    // HLT: absorbing until reset
    opcode = 4'hF;
    expect_cycle(1, F1, 0, "hlt_t1");
    expect_cycle(2, F2, 0, "hlt_t2");
    expect_cycle(3, IDLE, 0, "hlt_t3");
    repeat (20) expect_cycle(0, IDLE, 1, "halted");
    rst_n = 1'b0;
    #2 check_now(0, IDLE, 0, "halt_cleared");
    @(negedge clk) rst_n = 1'b1;
    run = 1'b0;
    @(posedge clk); #1;
    expect_cycle(0, IDLE, 0, "after_halt_pause");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
